// File: rtl/msrh_freelist_mp_if.sv
// Pop/push/checkpoint bundle between rename/commit logic and the multi-lane RNID freelist.
interface msrh_freelist_mp_if #(
  parameter int WIDTH  = 2,
  parameter int DEPTH  = 32,
  parameter int DATA_W = 7
);
  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]        i_pop_valid;
  logic                    o_pop_ready;
  logic [WIDTH*DATA_W-1:0] o_pop_id;
  logic [WIDTH-1:0]        i_push_valid;
  logic [WIDTH*DATA_W-1:0] i_push_id;
  logic [PTR_W-1:0]        o_head_ptr;
  logic                    i_restore_valid;
  logic [PTR_W-1:0]        i_restore_head;
  logic [PTR_W-1:0]        o_free_cnt;
  logic                    o_empty;
  logic                    o_err;

  modport master (
    output i_pop_valid, i_push_valid, i_push_id, i_restore_valid, i_restore_head,
    input  o_pop_ready, o_pop_id, o_head_ptr, o_free_cnt, o_empty, o_err
  );

  modport slave (
    input  i_pop_valid, i_push_valid, i_push_id, i_restore_valid, i_restore_head,
    output o_pop_ready, o_pop_id, o_head_ptr, o_free_cnt, o_empty, o_err
  );
endinterface

// File: rtl/msrh_freelist_mp.sv
// Multi-lane circular freelist of physical RNIDs: all-or-nothing grouped pops,
// multi-lane pushes, free count, and head checkpoint/restore for branch recovery.
module msrh_freelist_mp #(
  parameter int WIDTH     = 2,
  parameter int DEPTH     = 32,
  parameter int DATA_W    = 7,
  parameter int INIT_BASE = 32,
  parameter int INIT_CNT  = 32,
  localparam int PTR_W    = $clog2(DEPTH) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  msrh_freelist_mp_if.slave    fl_if
);
  localparam int IDX_W = PTR_W - 1;

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic                    err_q, err_d;

  logic [PTR_W-1:0]        free_cnt_s;
  logic [PTR_W-1:0]        pop_cnt_s;
  logic [PTR_W-1:0]        push_cnt_s;
  logic [IDX_W-1:0]        pop_idx_s  [WIDTH];
  logic [IDX_W-1:0]        push_idx_s [WIDTH];
  logic [WIDTH*DATA_W-1:0] pop_id_s;
  logic                    grant_s;
  logic [PTR_W:0]          occ_s;
  logic [PTR_W-1:0]        rest_dist_s;
  logic                    overflow_s;
  logic                    bad_restore_s;

  // Compacted lane offsets: each active lane takes the next slot after the lanes below it.
  always_comb begin
    pop_cnt_s  = '0;
    push_cnt_s = '0;
    for (int j = 0; j < WIDTH; j++) begin
      pop_idx_s[j]  = head_q[IDX_W-1:0] + pop_cnt_s[IDX_W-1:0];
      push_idx_s[j] = tail_q[IDX_W-1:0] + push_cnt_s[IDX_W-1:0];
      pop_cnt_s     = pop_cnt_s + PTR_W'(fl_if.i_pop_valid[j]);
      push_cnt_s    = push_cnt_s + PTR_W'(fl_if.i_push_valid[j]);
    end
  end

  always_comb begin
    pop_id_s = '0;
    for (int j = 0; j < WIDTH; j++) begin
      pop_id_s[j*DATA_W +: DATA_W] = mem_q[pop_idx_s[j]];
    end
  end

  // Grant, next pointers and error detection.
  always_comb begin
    free_cnt_s    = tail_q - head_q;
    grant_s       = (free_cnt_s >= pop_cnt_s) && !fl_if.i_restore_valid;
    tail_d        = tail_q + push_cnt_s;
    occ_s         = {1'b0, free_cnt_s} + {1'b0, push_cnt_s}
                    - (grant_s ? {1'b0, pop_cnt_s} : {(PTR_W+1){1'b0}});
    overflow_s    = occ_s > (PTR_W+1)'(DEPTH);
    rest_dist_s   = tail_d - fl_if.i_restore_head;
    bad_restore_s = fl_if.i_restore_valid && ({1'b0, rest_dist_s} > (PTR_W+1)'(DEPTH));
    if (fl_if.i_restore_valid) begin
      head_d = fl_if.i_restore_head;
    end else if (grant_s) begin
      head_d = head_q + pop_cnt_s;
    end else begin
      head_d = head_q;
    end
    err_d = err_q | overflow_s | bad_restore_s;
  end

  // Pointer/flag state and storage; reset preloads the initial RNID range.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      head_q <= '0;
      tail_q <= PTR_W'(INIT_CNT);
      err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (i < INIT_CNT) ? DATA_W'(INIT_BASE + i) : {DATA_W{1'b0}};
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      err_q  <= err_d;
      for (int j = 0; j < WIDTH; j++) begin
        if (fl_if.i_push_valid[j]) begin
          mem_q[push_idx_s[j]] <= fl_if.i_push_id[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign fl_if.o_pop_ready = grant_s;
  assign fl_if.o_pop_id    = pop_id_s;
  assign fl_if.o_head_ptr  = head_q;
  assign fl_if.o_free_cnt  = free_cnt_s;
  assign fl_if.o_empty     = (free_cnt_s == '0);
  assign fl_if.o_err       = err_q;
endmodule

// File: doc/msrh_freelist_mp.md
Name: msrh_freelist_mp

Overview:
- Multi-lane rename-ID freelist: circular FIFO of physical RNIDs for one dispatch lane group.
- Rename pops up to WIDTH free RNIDs per cycle; commit pushes up to WIDTH released old RNIDs per cycle.
- Successor to the fixed single-lane FLIST_SIZE freelist. Adds a parametrised lane count and depth, all-or-nothing pop grouping, free-count output, and head-pointer snapshot/restore for branch-checkpoint recovery.

Parameters:
- WIDTH, 2, pop/push lanes per cycle (normally DISP_SIZE); 1..8.
- DEPTH, 32, entries; power of two, >= WIDTH.
- DATA_W, 7, RNID width (RNID_W).
- INIT_BASE, 32, first RNID loaded at reset.
- INIT_CNT, 32, RNIDs loaded at reset; 0..DEPTH.
- PTR_W, $clog2(DEPTH)+1, pointer width including the wrap bit (derived; do not override).

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  synchronous active-low reset
- i_pop_valid  in  WIDTH  per-lane pop request mask (any bit pattern)
- o_pop_ready  out  1  whole pop group can be granted this cycle
- o_pop_id  out  WIDTH*DATA_W  RNID per requesting lane
- i_push_valid  in  WIDTH  per-lane push mask
- i_push_id  in  WIDTH*DATA_W  RNID per pushing lane
- o_head_ptr  out  PTR_W  current head, sampled by rename as a checkpoint
- i_restore_valid  in  1  rewind head to a checkpoint
- i_restore_head  in  PTR_W  previously sampled o_head_ptr
- o_free_cnt  out  $clog2(DEPTH)+1  entries currently free
- o_empty  out  1  o_free_cnt==0
- o_err  out  1  sticky overflow/underflow/illegal-restore flag

Behaviour:
- Storage: DEPTH x DATA_W array. Head and tail pointers are PTR_W wide with a wrap bit. Index = ptr[PTR_W-2:0].
- free_cnt = tail - head, modulo 2^PTR_W.
- Reset (i_reset_n==0 at posedge):
  - entry[i] = INIT_BASE+i for i<INIT_CNT; other entries are don't-care.
  - head=0; tail=INIT_CNT (INIT_CNT==DEPTH gives wrap=1, index 0).
  - o_err=0.
- Outputs after reset: o_free_cnt=INIT_CNT, o_empty=(INIT_CNT==0), o_head_ptr=0, o_pop_ready=1 if INIT_CNT>=WIDTH.
- Pop, combinational grant:
  - popcnt = popcount(i_pop_valid).
  - o_pop_ready = (free_cnt >= popcnt) & ~i_restore_valid.
  - Lane j with i_pop_valid[j] receives entry[head + (number of set bits in i_pop_valid[j-1:0])]. Lane order is compacted, lowest lane gets the oldest entry.
  - o_pop_id of non-requesting lanes is don't-care and must not be X-propagated into the pointers.
  - On posedge, if o_pop_ready & popcnt>0: head += popcnt.
  - If popcnt > free_cnt: no entry is consumed and the requester stalls. This is not an error.
- Push:
  - Lane j with i_push_valid[j] writes i_push_id[j] at tail + (set bits below j).
  - tail += popcount(i_push_valid).
  - Writes become visible one cycle later; there is no push->pop bypass in the same cycle.
- Overflow: if free_cnt + pushcnt - granted_popcnt > DEPTH, set o_err=1. Pointers still update (debug aid only); the simulation assertion fires.
- Restore:
  - When i_restore_valid: head <= i_restore_head; the pop grant is suppressed that cycle; pushes in the same cycle still advance tail.
  - Legal only if (tail_next - i_restore_head) <= DEPTH. Otherwise o_err=1 and head is still loaded.
  - Entries between i_restore_head and the old head are intact, because tail cannot overwrite them without overflow.
- Wrap-around: index arithmetic is modulo DEPTH; a group may straddle index DEPTH-1 -> 0 in either direction.
- Latency: pop data 0 cycles (combinational from registered head); pointer/count update 1 cycle.
- o_err clears only on reset.
- Reset mid-operation: reset has priority over push, pop and restore in the same cycle.

Test Plan:
- Reset with WIDTH=2, DEPTH=32, INIT_BASE=32, INIT_CNT=32 -> o_free_cnt=32, o_empty=0, o_head_ptr=0. Pop mask 2'b11 -> o_pop_id={33,32}; next cycle free_cnt=30, head=2.
- Sparse mask 2'b10 from fresh reset -> lane1 gets 32, head=1. Then mask 2'b01 -> lane0 gets 33.
- Drain to free_cnt=1, request 2'b11 -> o_pop_ready=0, head unchanged. Same cycle push lane0 id=5 -> next cycle free_cnt=2, pop 2'b11 grants {5, last id}.
- Wrap: with head index=31, free_cnt=2 and pops continuing across the boundary -> ids come from index 31 then 0; the wrap bit toggles; o_err stays 0.
- Checkpoint: sample o_head_ptr=4, pop 6 ids, then i_restore_valid with i_restore_head=4 plus a simultaneous push of 1 id -> o_pop_ready=0 that cycle; next cycle head=4, free_cnt increases by 7, next pops replay the same 6 ids.
- Overflow: at free_cnt=32, push 2'b01 -> o_err=1 and stays 1 until i_reset_n=0.
